// File: rtl/flash_erase_sched.sv
// flash_erase_sched: arbitrates two erase requesters (sector erase on port 0,
// bulk erase on port 1) onto a single SPI NOR flash through a byte-level SPI
// engine. The sequence is WREN, the erase command (plus a 3-byte address for a
// sector erase), then RDSR polling of the WIP bit until it clears or the poll
// budget runs out.
module flash_erase_sched #(
    parameter logic [15:0] POLL_GAP  = 16'd100,  // idle cycles between two status polls
    parameter logic [15:0] MAX_POLLS = 16'd5000, // RDSR reads allowed before timeout
    parameter logic [3:0]  CS_GAP    = 4'd5      // minimum CS-high cycles between transactions
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req0,
    input  logic [23:0] addr0,
    input  logic        req1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic        spi_start,
    output logic [7:0]  spi_byte,
    output logic        spi_last,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx
);

    // Flash opcodes used by the sequence.
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'hD8;
    localparam logic [7:0] OP_BE   = 8'hC7;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_DUMMY = 8'h00;

    // One-hot state encoding.
    typedef enum logic [9:0] {
        S_IDLE      = 10'b00_0000_0001,
        S_ARB       = 10'b00_0000_0010,
        S_WREN      = 10'b00_0000_0100,
        S_GAP1      = 10'b00_0000_1000,
        S_CMD       = 10'b00_0001_0000,
        S_ADDR      = 10'b00_0010_0000,
        S_GAP2      = 10'b00_0100_0000,
        S_POLL      = 10'b00_1000_0000,
        S_POLL_WAIT = 10'b01_0000_0000,
        S_FINISH    = 10'b10_0000_0000
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic [1:0]  done_q;
    logic        err_q;
    logic        spi_start_q;
    logic [7:0]  spi_byte_q;
    logic        spi_last_q;
    logic        pend_q;      // a byte has been launched and its spi_done is still due
    logic        rr_q;        // 1: requester 1 wins the next tie, 0: requester 0 wins
    logic [23:0] addr_q;
    logic [1:0]  byte_cnt_q;  // address byte index in ADDR, opcode/dummy phase in POLL
    logic [3:0]  gap_cnt_q;
    logic [15:0] wait_cnt_q;
    logic [15:0] poll_cnt_q;

    logic        win1_d;
    logic        gap_end_d;
    logic        wait_end_d;
    logic [16:0] poll_next_d;
    logic        poll_limit_d;
    logic [7:0]  addr_byte_d;
    logic        unused_rx_bits;

    // Only the WIP bit of the status register matters to the sequence.
    assign unused_rx_bits = ^spi_rx[7:1];

    // Round-robin winner: a lone request wins outright, a tie goes to rr_q.
    assign win1_d = (req0 && req1) ? rr_q : req1;

    // Terminal-count flags for the CS gap and poll spacing counters.
    assign gap_end_d    = ({1'b0, gap_cnt_q} + 5'd1) >= {1'b0, CS_GAP};
    assign wait_end_d   = ({1'b0, wait_cnt_q} + 17'd1) >= {1'b0, POLL_GAP};
    assign poll_next_d  = {1'b0, poll_cnt_q} + 17'd1;
    assign poll_limit_d = poll_next_d >= {1'b0, MAX_POLLS};

    // Address byte selected by the ADDR byte counter, most significant first.
    always_comb begin
        addr_byte_d = addr_q[23:16];
        case (byte_cnt_q)
            2'd0:    addr_byte_d = addr_q[23:16];
            2'd1:    addr_byte_d = addr_q[15:8];
            default: addr_byte_d = addr_q[7:0];
        endcase
    end

    // Sequencer: one byte launched per byte state, advance only on its spi_done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            spi_start_q <= 1'b0;
            spi_byte_q  <= 8'h00;
            spi_last_q  <= 1'b0;
            pend_q      <= 1'b0;
            rr_q        <= 1'b0;
            addr_q      <= 24'h00_0000;
            byte_cnt_q  <= 2'd0;
            gap_cnt_q   <= 4'd0;
            wait_cnt_q  <= 16'd0;
            poll_cnt_q  <= 16'd0;
        end else begin
            spi_start_q <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    // A request dropped before arbitration simply returns to IDLE.
                    if (req0 || req1) begin
                        grant_q    <= win1_d ? 2'b10 : 2'b01;
                        addr_q     <= addr0;
                        poll_cnt_q <= 16'd0;
                        byte_cnt_q <= 2'd0;
                        pend_q     <= 1'b0;
                        state_q    <= S_WREN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WREN: begin
                    if (!pend_q) begin
                        spi_start_q <= 1'b1;
                        spi_byte_q  <= OP_WREN;
                        spi_last_q  <= 1'b1;
                        pend_q      <= 1'b1;
                    end else if (spi_done) begin
                        pend_q    <= 1'b0;
                        gap_cnt_q <= 4'd0;
                        state_q   <= S_GAP1;
                    end
                end
                S_GAP1: begin
                    if (gap_end_d) begin
                        gap_cnt_q <= 4'd0;
                        state_q   <= S_CMD;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                S_CMD: begin
                    // Sector erase keeps CS low for the address; bulk erase ends here.
                    if (!pend_q) begin
                        spi_start_q <= 1'b1;
                        spi_byte_q  <= grant_q[1] ? OP_BE : OP_SE;
                        spi_last_q  <= grant_q[1];
                        pend_q      <= 1'b1;
                    end else if (spi_done) begin
                        pend_q <= 1'b0;
                        if (grant_q[1]) begin
                            gap_cnt_q <= 4'd0;
                            state_q   <= S_GAP2;
                        end else begin
                            byte_cnt_q <= 2'd0;
                            state_q    <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (!pend_q) begin
                        spi_start_q <= 1'b1;
                        spi_byte_q  <= addr_byte_d;
                        spi_last_q  <= (byte_cnt_q == 2'd2);
                        pend_q      <= 1'b1;
                    end else if (spi_done) begin
                        pend_q <= 1'b0;
                        if (byte_cnt_q == 2'd2) begin
                            byte_cnt_q <= 2'd0;
                            gap_cnt_q  <= 4'd0;
                            state_q    <= S_GAP2;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                S_GAP2: begin
                    if (gap_end_d) begin
                        gap_cnt_q  <= 4'd0;
                        byte_cnt_q <= 2'd0;
                        state_q    <= S_POLL;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                S_POLL: begin
                    // Phase 0 sends RDSR, phase 1 clocks in the status with a dummy byte.
                    if (!pend_q) begin
                        spi_start_q <= 1'b1;
                        spi_byte_q  <= (byte_cnt_q == 2'd0) ? OP_RDSR : OP_DUMMY;
                        spi_last_q  <= (byte_cnt_q != 2'd0);
                        pend_q      <= 1'b1;
                    end else if (spi_done) begin
                        pend_q <= 1'b0;
                        if (byte_cnt_q == 2'd0) begin
                            byte_cnt_q <= 2'd1;
                        end else begin
                            byte_cnt_q <= 2'd0;
                            poll_cnt_q <= poll_next_d[15:0];
                            if (!spi_rx[0]) begin
                                state_q <= S_FINISH;
                            end else if (poll_limit_d) begin
                                err_q   <= 1'b1;
                                rr_q    <= grant_q[0];
                                grant_q <= 2'b00;
                                state_q <= S_IDLE;
                            end else begin
                                wait_cnt_q <= 16'd0;
                                state_q    <= S_POLL_WAIT;
                            end
                        end
                    end
                end
                S_POLL_WAIT: begin
                    if (wait_end_d) begin
                        wait_cnt_q <= 16'd0;
                        state_q    <= S_POLL;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                S_FINISH: begin
                    done_q  <= grant_q;
                    rr_q    <= grant_q[0];
                    grant_q <= 2'b00;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    pend_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign spi_start = spi_start_q;
    assign spi_byte  = spi_byte_q;
    assign spi_last  = spi_last_q;

endmodule

// File: tb/tb_flash_erase_sched.sv
// Bench for flash_erase_sched: a table of erase operations run back to back
// against a simple SPI byte-engine model, followed by hand-written sequences
// for stray spi_done, request drop during polling and reset mid-operation.
module tb_flash_erase_sched;

    localparam int NV     = 6;
    localparam int CS_GAP = 5;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [23:0] addr0 = 24'h0;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic        spi_start;
    logic [7:0]  spi_byte;
    logic        spi_last;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx = 8'h00;

    flash_erase_sched #(
        .POLL_GAP (16'd4),
        .MAX_POLLS(16'd3),
        .CS_GAP   (4'd5)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req0     (req0),
        .addr0    (addr0),
        .req1     (req1),
        .grant    (grant),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .spi_start(spi_start),
        .spi_byte (spi_byte),
        .spi_last (spi_last),
        .spi_done (spi_done),
        .spi_rx   (spi_rx)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    // Engine configuration written by the stimulus process only.
    int dly_cfg = 1;
    int wip_cfg = 0;
    int op_id = 0;
    int stray_cnt = 0;

    // Engine state written by the engine process only.
    logic [7:0] log_byte[$];
    bit         log_last[$];
    int  done_cnt = 0;
    int  overlap_viol = 0;
    int  stable_viol = 0;
    int  gap_viol = 0;
    int  gap_checked = 0;

    // SPI byte engine: answers each spi_start with spi_done dly_cfg cycles later;
    // the dummy byte after an RDSR returns WIP=1 for the first wip_cfg polls.
    initial begin
        int         cyc = 0;
        int         last_done_cyc = 0;
        int         cnt = 0;
        int         eng_op = 0;
        int         wip_used = 0;
        int         eng_stray = 0;
        bit         pending = 1'b0;
        bit         was_pending;
        logic [7:0] pend_byte = 8'h00;
        bit         pend_last = 1'b0;
        bit         pend_dummy = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        logic [7:0] prev2_byte = 8'h00;
        bit         prev_last = 1'b0;
        forever begin
            @(negedge sys_clk);
            cyc++;
            spi_done = 1'b0;
            if (eng_op != op_id) begin
                eng_op = op_id;
                wip_used = 0;
            end
            if (!sys_rst_n) begin
                pending = 1'b0;
            end else begin
                was_pending = pending;
                if (pending) begin
                    if (spi_byte !== pend_byte) stable_viol++;
                    cnt--;
                    if (cnt <= 0) begin
                        spi_done = 1'b1;
                        if (pend_dummy) begin
                            spi_rx = (wip_used < wip_cfg) ? 8'h03 : 8'h02;
                            wip_used++;
                        end else begin
                            spi_rx = 8'hA5;
                        end
                        pending = 1'b0;
                        done_cnt++;
                        if (pend_last) last_done_cyc = cyc;
                    end
                end else if (eng_stray != stray_cnt) begin
                    eng_stray = stray_cnt;
                    spi_done = 1'b1;
                    spi_rx = 8'hFF;
                end
                if (spi_start === 1'b1) begin
                    if (was_pending) overlap_viol++;
                    // CS-high time is checked inside an operation, not after polls or between ops.
                    if (prev_last && spi_byte != 8'h06 && !(prev_byte == 8'h00 && prev2_byte == 8'h05)) begin
                        gap_checked++;
                        if (cyc - last_done_cyc - 1 < CS_GAP) gap_viol++;
                    end
                    log_byte.push_back(spi_byte);
                    log_last.push_back(spi_last);
                    pend_dummy = (spi_byte == 8'h00 && prev_byte == 8'h05);
                    pending = 1'b1;
                    cnt = dly_cfg;
                    pend_byte = spi_byte;
                    pend_last = spi_last;
                    prev2_byte = prev_byte;
                    prev_byte = spi_byte;
                    prev_last = spi_last;
                end
            end
        end
    end

    typedef struct {
        bit           r0;
        bit           r1;
        logic [23:0]  addr;
        int           wip;
        int           dly;
        logic [1:0]   exp_grant;
        logic [1:0]   exp_done;
        logic         exp_err;
        int           exp_polls;
        int           nbytes;
        logic [127:0] bytes;   // right-justified, first byte most significant
        logic [15:0]  lastm;   // right-justified, bit per byte in the same order
    } vec_t;

    vec_t vecs[NV];
    int   log_base = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic apply(input int i);
        if (i < NV) begin
            req0 = vecs[i].r0;
            req1 = vecs[i].r1;
            addr0 = vecs[i].addr;
            wip_cfg = vecs[i].wip;
            dly_cfg = vecs[i].dly;
        end else begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        op_id++;
        log_base = log_byte.size();
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (grant == 2'b00 && n < 100) begin
            tick(1);
            n++;
        end
        chk({name, "_grant_timeout"}, 128'(n < 100), 128'(1));
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (done == 2'b00 && err == 1'b0 && n < 20000) begin
            tick(1);
            n++;
        end
        chk({name, "_end_timeout"}, 128'(n < 20000), 128'(1));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 24'hA55A3C, 0,   2,  2'b01, 2'b01, 1'b0, 1, 7,
                    128'h06D8A55A3C0500, 16'b1000101};
        vecs[1] = '{1'b1, 1'b1, 24'h000000, 0,   1,  2'b10, 2'b10, 1'b0, 1, 4,
                    128'h06C70500, 16'b1101};
        vecs[2] = '{1'b1, 1'b0, 24'h032000, 2,   1,  2'b01, 2'b01, 1'b0, 3, 11,
                    128'h06D8032000050005000500, 16'b10001010101};
        vecs[3] = '{1'b0, 1'b1, 24'h000000, 100, 3,  2'b10, 2'b00, 1'b1, 3, 8,
                    128'h06C7050005000500, 16'b11010101};
        vecs[4] = '{1'b1, 1'b0, 24'hFF0081, 1,   37, 2'b01, 2'b01, 1'b0, 2, 9,
                    128'h06D8FF008105000500, 16'b100010101};
        vecs[5] = '{1'b1, 1'b1, 24'h000000, 0,   1,  2'b10, 2'b10, 1'b0, 1, 4,
                    128'h06C70500, 16'b1101};

        // Reset state.
        tick(3);
        chk("reset_outputs", 128'({grant, done, err, busy, spi_start, spi_byte, spi_last}), 128'(0));

        // Table of operations, each started from the done/err cycle of the previous one.
        apply(0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            string nm;
            int polls;
            logic [127:0] eb;
            logic [15:0] em;
            nm = $sformatf("vec%0d", i);
            wait_grant(nm);
            chk({nm, "_grant"}, 128'(grant), 128'(vecs[i].exp_grant));
            chk({nm, "_busy"}, 128'(busy), 128'(1));
            wait_end(nm);
            chk({nm, "_done"}, 128'(done), 128'(vecs[i].exp_done));
            chk({nm, "_err"}, 128'(err), 128'(vecs[i].exp_err));
            chk({nm, "_grant_cleared"}, 128'({grant, busy}), 128'(0));
            chk({nm, "_nbytes"}, 128'(log_byte.size() - log_base), 128'(vecs[i].nbytes));
            eb = vecs[i].bytes;
            em = vecs[i].lastm;
            polls = 0;
            for (int j = 0; j < vecs[i].nbytes; j++) begin
                logic [8:0] got;
                logic [8:0] exp;
                int n;
                n = vecs[i].nbytes;
                exp = {em[n-1-j], eb[(n-1-j)*8 +: 8]};
                if (log_base + j < log_byte.size()) begin
                    got = {log_last[log_base+j], log_byte[log_base+j]};
                    if (log_byte[log_base+j] == 8'h05) polls++;
                end else begin
                    got = 9'bx;
                end
                chk($sformatf("%s_byte%0d_last_data", nm, j), 128'(got), 128'(exp));
            end
            chk({nm, "_polls"}, 128'(polls), 128'(vecs[i].exp_polls));
            $display("TXN vec%0d grant=%b done=%b err=%b bytes=%0d polls=%0d",
                     i, vecs[i].exp_grant, done, err, log_byte.size() - log_base, polls);
            apply(i + 1);
            tick(1);
            chk({nm, "_pulse_width"}, 128'({done, err}), 128'(0));
        end

        // A spi_done with nothing outstanding while idle is ignored.
        tick(3);
        log_base = log_byte.size();
        stray_cnt++;
        tick(6);
        chk("stray_done_idle", 128'({busy, log_byte.size() != log_base}), 128'(0));
        $display("TXN stray spi_done busy=%b", busy);

        // Dropping req1 during POLL_WAIT does not abort the bulk erase.
        begin
            int base;
            int n;
            req1 = 1'b1;
            wip_cfg = 2;
            dly_cfg = 1;
            op_id++;
            log_base = log_byte.size();
            base = done_cnt;
            n = 0;
            while (done_cnt < base + 4 && n < 500) begin
                tick(1);
                n++;
            end
            chk("drop_first_poll_timeout", 128'(n < 500), 128'(1));
            tick(1);
            chk("drop_busy", 128'({busy, grant}), 128'({1'b1, 2'b10}));
            req1 = 1'b0;
            wait_end("drop");
            chk("drop_done", 128'({done, err}), 128'({2'b10, 1'b0}));
            chk("drop_nbytes", 128'(log_byte.size() - log_base), 128'(8));
            $display("TXN drop_req1 done=%b bytes=%0d", done, log_byte.size() - log_base);
            tick(2);
        end

        // Reset during ADDR abandons the sector erase; req1 then restarts from WREN.
        begin
            int base;
            int n;
            req0 = 1'b1;
            req1 = 1'b1;
            addr0 = 24'h123456;
            wip_cfg = 0;
            dly_cfg = 1;
            op_id++;
            base = done_cnt;
            n = 0;
            while (done_cnt < base + 4 && n < 500) begin
                tick(1);
                n++;
            end
            chk("rst_addr_timeout", 128'(n < 500), 128'(1));
            chk("rst_pre_grant", 128'(grant), 128'(2'b01));
            #1 sys_rst_n = 1'b0;
            #1 chk("rst_async_outputs", 128'({grant, done, err, busy, spi_start, spi_byte, spi_last}), 128'(0));
            req0 = 1'b0;
            tick(3);
            chk("rst_held_quiet", 128'({grant, done, err, busy, spi_start}), 128'(0));
            log_base = log_byte.size();
            op_id++;
            sys_rst_n = 1'b1;
            wait_grant("rst_restart");
            chk("rst_restart_grant", 128'(grant), 128'(2'b10));
            wait_end("rst_restart");
            chk("rst_restart_done", 128'({done, err}), 128'({2'b10, 1'b0}));
            if (log_byte.size() - log_base >= 2) begin
                chk("rst_restart_first_bytes", 128'({log_byte[log_base], log_byte[log_base+1]}), 128'(16'h06C7));
            end else begin
                chk("rst_restart_nbytes", 128'(log_byte.size() - log_base), 128'(4));
            end
            $display("TXN reset_in_addr restart grant=10 done=%b bytes=%0d", done, log_byte.size() - log_base);
            req1 = 1'b0;
            tick(3);
        end

        // Engine-side protocol observations accumulated over the whole run.
        chk("spi_start_while_outstanding", 128'(overlap_viol), 128'(0));
        chk("spi_byte_unstable", 128'(stable_viol), 128'(0));
        chk("cs_gap_short", 128'(gap_viol), 128'(0));
        chk("cs_gap_observed", 128'(gap_checked > 0), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
